multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-cycle adder/subtractor controller for wide operands.
- Sequences one narrow SLICE-bit ripple-carry slice across WIDTH/SLICE beats and holds the inter-beat carry in a register.
- Trades latency for area versus a full-width ripple chain.
- Sits between an operand producer and a result consumer; valid/ready handshake on both sides.

Parameters:
- WIDTH, 60, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 15, width of the ripple slice used per beat.
- BEATS (localparam), WIDTH/SLICE, number of slice evaluations per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used for add only.
- op_sub  in  1  1 = compute a - b, 0 = compute a + b + cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state to IDLE; beat and carry to 0.
  - sum, cout, ovf and out_valid to 0.
  - Any operation in progress is abandoned with no output.
  - rst has priority over all other inputs.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = !IDLE.
- IDLE: on in_valid (in_ready=1), register the operands:
  - a_r = a.
  - b_r = op_sub ? ~b : b.
  - carry = op_sub ? 1 : cin (op_sub overrides cin).
  - beat = 0; clear sum register; go to RUN.
- RUN: each cycle, the slice adds a_r[beat*SLICE +: SLICE], b_r[same] and carry.
  - Write the slice sum into sum[beat*SLICE +: SLICE].
  - carry = slice carry-out; beat = beat+1.
  - After the beat==BEATS-1 write: cout = final carry, compute ovf, go to DONE.
- ovf = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]), evaluated with the final sum.
- DONE: sum, cout and ovf held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE.
  - No new accept in the DONE cycle.
- Latency and throughput:
  - Accept edge at cycle t; out_valid asserted at cycle t+BEATS (4 at defaults).
  - Max throughput: one operation per BEATS+2 cycles.
- Boundary conditions:
  - in_valid during RUN or DONE is ignored; operands must be held by the producer until accepted.
  - Inputs a, b, cin and op_sub may change after the accept edge with no effect.
  - BEATS==1 (SLICE==WIDTH) is legal: RUN lasts one cycle.
  - beat counter width is clog2(BEATS) with a minimum of 1; it never exceeds BEATS-1.

Decomposition:
- Shared package (adder_ctrl_pkg):
  - state enum {IDLE, RUN, DONE}.
  - helper function for BEATS and the counter width.
- Sub-module ripple_add_slice (parameter SLICE): purely combinational.
  - SLICE full_adder instances generated in a loop.
  - Carry chained bit i to i+1; ports a, b, cin, sum, cout.

Test Plan:
All scenarios use WIDTH=60, SLICE=15.
- Basic add: a=1, b=2, cin=0, op_sub=0 -> sum=3, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFF_FFFF_FFFF_FFFF, b=1 -> sum=0, cout=1, ovf=0; carry propagates across all 4 beats.
- Subtract with borrow: a=5, b=7, op_sub=1, cin=1 -> sum=0xFFF_FFFF_FFFF_FFFE, cout=0, ovf=0 (cin ignored).
- Signed overflow: a=0x7FF_FFFF_FFFF_FFFF, b=1, op_sub=0 -> sum=0x800_0000_0000_0000, ovf=1, cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands.
  - Required: out_valid, sum and cout stable; in_ready=0; new operands not taken.
  - Then out_ready=1 -> IDLE, and the next request is accepted one cycle later.
- Reset mid-operation: rst=1 for one cycle at beat 2 of RUN.
  - Next cycle: in_ready=1, out_valid=0, sum=0, busy=0.
  - Then a=10, b=20 -> sum=30.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-word add/subtract sequencer.
// Derives the beat count and the beat counter width from the operand and slice widths.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calcBeats(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-beat configuration still needs a one-bit counter.
    function automatic int calcCntWidth(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ripple_add_slice.sv
// Narrow combinational ripple-carry adder reused on every beat of a wide operation.
// Built from chained single-bit full adders.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module ripple_add_slice #(
    parameter int SLICE = 15
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    logic [SLICE:0] carryChain;

    assign carryChain[0] = cin_i;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (carryChain[i]),
            .sum_o (sum_o[i]),
            .cout_o(carryChain[i+1])
        );
    end

    assign cout_o = carryChain[SLICE];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built by stepping one SLICE-bit ripple adder across WIDTH/SLICE beats.
// The inter-beat carry is held in a register; valid/ready handshakes on both sides.
module multiword_add_sequencer
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 60,
    parameter int SLICE = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             op_sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int              BEATS     = calcBeats(WIDTH, SLICE);
    localparam int              CNTW      = calcCntWidth(BEATS);
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

    state_e            state_q;
    logic [CNTW-1:0]   beat_q;
    logic              carry_q;
    logic [WIDTH-1:0]  aReg_q;
    logic [WIDTH-1:0]  bReg_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [SLICE-1:0]  aSlice_d;
    logic [SLICE-1:0]  bSlice_d;
    logic [SLICE-1:0]  sliceSum_d;
    logic              sliceCout_d;
    logic              ovf_d;

    // Route the current beat's slice of both operands into the shared adder.
    always_comb begin
        aSlice_d = '0;
        bSlice_d = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == CNTW'(i)) begin
                aSlice_d = aReg_q[i*SLICE +: SLICE];
                bSlice_d = bReg_q[i*SLICE +: SLICE];
            end
        end
    end

    ripple_add_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a_i   (aSlice_d),
        .b_i   (bSlice_d),
        .cin_i (carry_q),
        .sum_o (sliceSum_d),
        .cout_o(sliceCout_d)
    );

    // On the last beat the top slice result carries the final sum MSB.
    assign ovf_d = (aReg_q[WIDTH-1] == bReg_q[WIDTH-1]) &&
                   (sliceSum_d[SLICE-1] != aReg_q[WIDTH-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            carry_q <= 1'b0;
            aReg_q  <= '0;
            bReg_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        aReg_q  <= a_i;
                        bReg_q  <= op_sub_i ? ~b_i : b_i;
                        carry_q <= op_sub_i ? 1'b1 : cin_i;
                        beat_q  <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat_q == CNTW'(i)) begin
                            sum_q[i*SLICE +: SLICE] <= sliceSum_d;
                        end
                    end
                    carry_q <= sliceCout_d;
                    if (beat_q == LAST_BEAT) begin
                        beat_q  <= '0;
                        cout_q  <= sliceCout_d;
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end else begin
                        beat_q <= beat_q + CNTW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: arithmetic reference model with per-cycle
// compare, directed corner cases, backpressure, mid-operation reset and randomized traffic.
module tb_multiword_add_sequencer;

    localparam int WIDTH = 60;
    localparam int SLICE = 15;
    localparam int BEATS = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } res_t;

    multiword_add_sequencer #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .op_sub_i   (op_sub),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .cout_o     (cout),
        .ovf_o      (ovf),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // The result from plain integer arithmetic: unsigned view for sum/carry, signed view for overflow.
    function automatic res_t refCompute(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                        input logic c, input logic s);
        res_t        r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] tot;
        longint      sa;
        longint      sb;
        longint      tv;
        longint      maxPos;
        longint      minNeg;
        maxPos = (longint'(1) << (WIDTH - 1)) - 1;
        minNeg = -(longint'(1) << (WIDTH - 1));
        ua = {{(64-WIDTH){1'b0}}, av};
        ub = {{(64-WIDTH){1'b0}}, bv};
        sa = $signed({{(64-WIDTH){av[WIDTH-1]}}, av});
        sb = $signed({{(64-WIDTH){bv[WIDTH-1]}}, bv});
        if (s) begin
            tot = ua - ub;
            r.c = (ua >= ub);
            tv  = sa - sb;
        end else begin
            tot = ua + ub + 64'(c);
            r.c = tot[WIDTH];
            tv  = sa + sb + longint'(c);
        end
        r.s = tot[WIDTH-1:0];
        r.o = (tv > maxPos) || (tv < minNeg);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] randOperand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return WIDTH'($urandom_range(0, 15));
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: an accepted request yields its arithmetic result BEATS cycles later
    // and holds it until the consumer takes it.
    bit   mBusy  = 1'b0;
    bit   mValid = 1'b0;
    int   mCnt   = 0;
    res_t mPend;
    res_t mRes;

    always @(posedge clk) begin
        if (rst) begin
            mBusy  = 1'b0;
            mValid = 1'b0;
            mCnt   = 0;
        end else if (!mBusy) begin
            if (in_valid) begin
                mPend = refCompute(a, b, cin, op_sub);
                mBusy = 1'b1;
                mCnt  = 0;
            end
        end else if (!mValid) begin
            mCnt++;
            if (mCnt == BEATS) begin
                mValid = 1'b1;
                mRes   = mPend;
            end
        end else if (out_ready) begin
            mBusy  = 1'b0;
            mValid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cyc_in_ready", 64'(in_ready), 64'(!mBusy));
            checkOutput("cyc_out_valid", 64'(out_valid), 64'(mValid));
            checkOutput("cyc_busy", 64'(busy), 64'(mBusy));
            if (mValid) begin
                checkOutput("cyc_sum", 64'(sum), 64'(mRes.s));
                checkOutput("cyc_cout", 64'(cout), 64'(mRes.c));
                checkOutput("cyc_ovf", 64'(ovf), 64'(mRes.o));
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic c, input logic s);
        int n;
        n        = 0;
        a        = av;
        b        = bv;
        cin      = c;
        op_sub   = s;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("accept_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a        = randOperand();
        b        = randOperand();
        cin      = ~c;
        op_sub   = ~s;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic runDirected(input string name, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic c, input logic s,
                               input logic [WIDTH-1:0] expSum, input logic expCout,
                               input logic expOvf);
        int lat;
        applyStimulus(av, bv, c, s);
        waitResult(lat);
        checkOutput({name, "_latency"}, 64'(lat), 64'(BEATS));
        checkOutput({name, "_sum"}, 64'(sum), 64'(expSum));
        checkOutput({name, "_cout"}, 64'(cout), 64'(expCout));
        checkOutput({name, "_ovf"}, 64'(ovf), 64'(expOvf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        res_t r;
        int   lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        rst   = 1'b0;
        cmpEn = 1'b1;

        r = refCompute(60'd1, 60'd2, 1'b0, 1'b0);
        checkOutput("model_add", 64'(r), 64'({60'd3, 1'b0, 1'b0}));
        r = refCompute(60'hFFF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0);
        checkOutput("model_ripple", 64'(r), 64'({60'd0, 1'b1, 1'b0}));
        r = refCompute(60'd5, 60'd7, 1'b1, 1'b1);
        checkOutput("model_sub", 64'(r), 64'({60'hFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}));
        r = refCompute(60'h7FF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0);
        checkOutput("model_ovf", 64'(r), 64'({60'h800_0000_0000_0000, 1'b0, 1'b1}));

        runDirected("basic_add", 60'd1, 60'd2, 1'b0, 1'b0, 60'd3, 1'b0, 1'b0);
        runDirected("full_ripple", 60'hFFF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0, 60'd0, 1'b1, 1'b0);
        runDirected("sub_borrow", 60'd5, 60'd7, 1'b1, 1'b1, 60'hFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        runDirected("signed_ovf", 60'h7FF_FFFF_FFFF_FFFF, 60'd1, 1'b0, 1'b0,
                    60'h800_0000_0000_0000, 1'b0, 1'b1);
        runDirected("add_cin", 60'd40, 60'd2, 1'b1, 1'b0, 60'd43, 1'b0, 1'b0);

        // Backpressure: result must hold while a new request waits at the input.
        applyStimulus(60'd100, 60'd23, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("bp_latency", 64'(lat), 64'(BEATS));
        in_valid = 1'b1;
        a        = 60'd7;
        b        = 60'd8;
        cin      = 1'b0;
        op_sub   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_sum", 64'(sum), 64'd123);
            checkOutput("bp_cout", 64'(cout), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_idle_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_idle_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("bp_next_busy", 64'(busy), 64'd1);
        checkOutput("bp_next_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp_next_latency", 64'(lat), 64'(BEATS));
        checkOutput("bp_next_sum", 64'(sum), 64'd15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while the third beat is pending abandons the operation.
        applyStimulus(60'h123_4567_89AB_CDEF, 60'hFED_CBA9_8765_4321, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        runDirected("after_rst", 60'd10, 60'd20, 1'b0, 1'b0, 60'd30, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            a         = randOperand();
            b         = randOperand();
            cin       = 1'($urandom_range(0, 1));
            op_sub    = 1'($urandom_range(0, 1));
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        checkOutput("drain_idle", 64'(in_ready), 64'd1);

        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
